uart_tx_feeder: RTL and testbench

- Upstream stage of the UART transmitter, in the baud_clk domain.
- Buffers producer bytes in a small synchronous FIFO and launches one frame at a time into the TX using its start / data_in / tx_busy handshake.
- Optionally inserts a programmable idle gap between frames.
- Gives the producer a valid/ready write port with no dropped bytes.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync_fifo.sv | 62 ++++++
 rtl/uart_tx_feeder.sv | 109 ++++++++++
 tb/tb_uart_tx_feeder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
//   UART_DATA_WIDTH : default character width used by the TX and its feeder.
//   feeder_state_t  : frame-launch FSM states of uart_tx_feeder.
package uart_pkg;

    localparam int unsigned UART_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2,
        GAP  = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO with show-ahead head output.
// Ports:
//   baud_clk, rst_n : clock, asynchronous active-low reset
//   push, pop       : write / read strobes (ignored when full / empty)
//   flush           : synchronous clear, overrides a simultaneous push or pop
//   din, dout       : write data, current head entry
//   level           : occupancy 0..DEPTH
//   empty, full     : occupancy flags
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                     baud_clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DATA_WIDTH-1:0]    din,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [AW:0]           wr_ptr_q;
    logic [AW:0]           rd_ptr_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge baud_clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and launches them one frame at a time into the UART TX
// through its start / data_in / tx_busy handshake, with an optional idle gap.
// Ports:
//   baud_clk, rst_n     : bit-rate clock, asynchronous active-low reset
//   wr_valid, wr_data   : producer byte; accepted when wr_valid && wr_ready
//   wr_ready            : !full && !flush
//   flush               : synchronous FIFO clear (FSM and in-flight frame unaffected)
//   tx_start, tx_data   : to TX start / data_in
//   tx_busy             : from TX
//   level, empty, full  : FIFO occupancy
//   frame_done          : one-cycle pulse when a launched frame completes
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned GAP_BITS   = 0
) (
    input  logic                     baud_clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     wr_ready,
    input  logic                     flush,
    output logic                     tx_start,
    output logic [DATA_WIDTH-1:0]    tx_data,
    input  logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full,
    output logic                     frame_done
);

    localparam int unsigned GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    feeder_state_t         state_q;
    logic [GW-1:0]         gap_cnt_q;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  push;
    logic                  pop;

    assign wr_ready = !full && !flush;
    assign push     = wr_valid && wr_ready;
    // A flush discards a simultaneous pop, so no launch happens in that cycle either.
    assign pop      = (state_q == IDLE) && !empty && !flush;

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .baud_clk (baud_clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .din      (wr_data),
        .dout     (fifo_dout),
        .level    (level),
        .empty    (empty),
        .full     (full)
    );

    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gap_cnt_q  <= '0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // tx_busy seen here comes from a foreign source and is ignored.
                    if (pop) begin
                        tx_data  <= fifo_dout;
                        tx_start <= 1'b1;
                        state_q  <= REQ;
                    end
                end
                REQ: begin
                    if (tx_busy) begin
                        tx_start <= 1'b0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (!tx_busy) begin
                        frame_done <= 1'b1;
                        if (GAP_BITS == 0) begin
                            state_q <= IDLE;
                        end else begin
                            gap_cnt_q <= '0;
                            state_q   <= GAP;
                        end
                    end
                end
                GAP: begin
                    gap_cnt_q <= gap_cnt_q + GAP_ONE;
                    if (gap_cnt_q == GAP_LAST) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder. Two instances (GAP_BITS = 0 and 3) share the
// producer inputs; each drives its own TX stub. A queue-level model predicts every output.
module tb_uart_tx_feeder;

    logic       baud_clk;
    logic       rst_n;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       flush;
    logic [1:0] wr_ready;
    logic [1:0] tx_start;
    logic [1:0] tx_busy;
    logic [1:0] empty;
    logic [1:0] full;
    logic [1:0] frame_done;
    logic [7:0] tx_data [2];
    logic [3:0] level   [2];

    uart_tx_feeder #(.DATA_WIDTH(8), .DEPTH(8), .GAP_BITS(0)) dut0 (
        .baud_clk (baud_clk), .rst_n (rst_n), .wr_valid (wr_valid), .wr_data (wr_data),
        .wr_ready (wr_ready[0]), .flush (flush), .tx_start (tx_start[0]),
        .tx_data (tx_data[0]), .tx_busy (tx_busy[0]), .level (level[0]),
        .empty (empty[0]), .full (full[0]), .frame_done (frame_done[0])
    );

    uart_tx_feeder #(.DATA_WIDTH(8), .DEPTH(8), .GAP_BITS(3)) dut3 (
        .baud_clk (baud_clk), .rst_n (rst_n), .wr_valid (wr_valid), .wr_data (wr_data),
        .wr_ready (wr_ready[1]), .flush (flush), .tx_start (tx_start[1]),
        .tx_data (tx_data[1]), .tx_busy (tx_busy[1]), .level (level[1]),
        .empty (empty[1]), .full (full[1]), .frame_done (frame_done[1])
    );

    initial begin
        baud_clk = 1'b0;
        forever #5 baud_clk = ~baud_clk;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int fd_cnt [2] = '{0, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- TX stub: busy one cycle after start, held busy_len cycles
    logic stub_hold = 1'b0;
    logic rand_len  = 1'b0;
    int   busy_len  = 11;
    int   stub_rem [2];

    initial forever begin
        @(posedge baud_clk or negedge rst_n);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                tx_busy[i] <= 1'b0;
                stub_rem[i] = 0;
            end else if (!tx_busy[i]) begin
                if (tx_start[i]) begin
                    tx_busy[i] <= 1'b1;
                    stub_rem[i] = rand_len ? int'($urandom_range(1, 14)) : busy_len;
                end
            end else if (!stub_hold) begin
                stub_rem[i]--;
                if (stub_rem[i] == 0) tx_busy[i] <= 1'b0;
            end
        end
    end

    // ---------------- Behavioural model: byte queue plus frame phase / gap countdown
    localparam int GAPV [2] = '{0, 3};
    int         m_cnt   [2];
    logic [7:0] m_q     [2][8];
    int         m_phase [2];   // 0 waiting, 1 requesting, 2 frame on line, 3 idle gap
    int         m_gap   [2];
    logic       m_start [2];
    logic [7:0] m_data  [2];
    logic       m_fd    [2];

    initial forever begin
        @(posedge baud_clk or negedge rst_n);
        for (int i = 0; i < 2; i++) begin
            logic acc;
            logic lau;
            if (!rst_n) begin
                m_cnt[i] = 0; m_phase[i] = 0; m_gap[i] = 0;
                m_start[i] = 1'b0; m_data[i] = 8'h00; m_fd[i] = 1'b0;
            end else begin
                acc = wr_valid && (m_cnt[i] < 8) && !flush;
                lau = (m_phase[i] == 0) && (m_cnt[i] > 0) && !flush;
                m_fd[i] = 1'b0;
                case (m_phase[i])
                    0: if (lau) begin
                        m_data[i] = m_q[i][0];
                        m_start[i] = 1'b1;
                        m_phase[i] = 1;
                    end
                    1: if (tx_busy[i]) begin
                        m_start[i] = 1'b0;
                        m_phase[i] = 2;
                    end
                    2: if (!tx_busy[i]) begin
                        m_fd[i] = 1'b1;
                        m_gap[i] = GAPV[i];
                        m_phase[i] = (GAPV[i] == 0) ? 0 : 3;
                    end
                    default: begin
                        m_gap[i]--;
                        if (m_gap[i] == 0) m_phase[i] = 0;
                    end
                endcase
                if (flush) begin
                    m_cnt[i] = 0;
                end else begin
                    if (lau) begin
                        for (int j = 0; j < 7; j++) m_q[i][j] = m_q[i][j+1];
                        m_cnt[i]--;
                    end
                    if (acc) begin
                        m_q[i][m_cnt[i]] = wr_data;
                        m_cnt[i]++;
                    end
                end
            end
        end
    end

    // ---------------- Compare process: every cycle out of reset
    initial forever begin
        @(posedge baud_clk);
        #1;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("tx_start[%0d]", i), 32'(tx_start[i]), 32'(m_start[i]));
                chk($sformatf("tx_data[%0d]", i), 32'(tx_data[i]), 32'(m_data[i]));
                chk($sformatf("frame_done[%0d]", i), 32'(frame_done[i]), 32'(m_fd[i]));
                chk($sformatf("level[%0d]", i), 32'(level[i]), m_cnt[i]);
                chk($sformatf("empty[%0d]", i), 32'(empty[i]), 32'(m_cnt[i] == 0));
                chk($sformatf("full[%0d]", i), 32'(full[i]), 32'(m_cnt[i] == 8));
                chk($sformatf("wr_ready[%0d]", i), 32'(wr_ready[i]),
                    32'((m_cnt[i] < 8) && !flush));
                if (frame_done[i]) fd_cnt[i]++;
            end
        end
    end

    // ---------------- Directed helpers (all called on a negedge)
    task automatic check_reset_values(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_tx_start[%0d]", tag, i), 32'(tx_start[i]), 32'd0);
            chk($sformatf("%s_tx_data[%0d]", tag, i), 32'(tx_data[i]), 32'd0);
            chk($sformatf("%s_frame_done[%0d]", tag, i), 32'(frame_done[i]), 32'd0);
            chk($sformatf("%s_level[%0d]", tag, i), 32'(level[i]), 32'd0);
            chk($sformatf("%s_empty[%0d]", tag, i), 32'(empty[i]), 32'd1);
            chk($sformatf("%s_full[%0d]", tag, i), 32'(full[i]), 32'd0);
        end
    endtask

    task automatic push_hold(input logic [7:0] b);
        int t = 0;
        @(negedge baud_clk);
        wr_valid = 1'b1;
        wr_data  = b;
        while (!wr_ready[0] && t < 100) begin
            @(negedge baud_clk);
            t++;
        end
        if (t >= 100) chk("push_timeout", 32'(t), 32'd0);
        @(negedge baud_clk);
        wr_valid = 1'b0;
    endtask

    // Edges from a frame_done pulse to the next tx_start rise.
    task automatic measure_gap(input int i, input int exp_gap);
        int t = 0;
        while (frame_done[i] !== 1'b1 && t < 200) begin
            @(negedge baud_clk);
            t++;
        end
        if (t >= 200) chk($sformatf("frame_done_timeout[%0d]", i), 32'(t), 32'd0);
        t = 0;
        do begin
            @(negedge baud_clk);
            t++;
        end while (tx_start[i] !== 1'b1 && t < 50);
        chk($sformatf("gap_cycles[%0d]", i), 32'(t), 32'(exp_gap));
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge baud_clk);
    endtask

    int snap0;

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; flush = 1'b0;
        wait_cycles(3);
        check_reset_values("reset");
        chk("reset_wr_ready", 32'(wr_ready[0]), 32'd1);
        rst_n = 1'b1;
        wait_cycles(2);

        // Single byte
        wr_valid = 1'b1; wr_data = 8'hA5;
        @(negedge baud_clk);
        wr_valid = 1'b0;
        chk("single_level_after_push", 32'(level[0]), 32'd1);
        chk("single_start_k", 32'(tx_start[0]), 32'd0);
        @(negedge baud_clk);
        chk("single_start_k1", 32'(tx_start[0]), 32'd1);
        chk("single_data", 32'(tx_data[0]), 32'hA5);
        chk("single_level_k1", 32'(level[0]), 32'd0);
        @(negedge baud_clk);
        chk("single_start_k2", 32'(tx_start[0]), 32'd1);
        @(negedge baud_clk);
        chk("single_start_k3", 32'(tx_start[0]), 32'd0);
        wait_cycles(20);
        chk("single_fd_count", 32'(fd_cnt[0]), 32'd1);

        // Back-to-back and gap timing
        snap0 = fd_cnt[0];
        wr_valid = 1'b1; wr_data = 8'h11;
        @(negedge baud_clk); wr_data = 8'h22;
        @(negedge baud_clk); wr_data = 8'h33;
        @(negedge baud_clk); wr_valid = 1'b0;
        fork
            measure_gap(0, 1);
            measure_gap(1, 4);
        join
        wait_cycles(80);
        chk("b2b_fd_count", 32'(fd_cnt[0] - snap0), 32'd3);

        // Fill with the TX held busy
        stub_hold = 1'b1;
        for (int b = 0; b < 9; b++) push_hold(8'(8'h40 + b));
        chk("fill_level", 32'(level[0]), 32'd8);
        chk("fill_full", 32'(full[0]), 32'd1);
        chk("fill_wr_ready", 32'(wr_ready[0]), 32'd0);
        wr_valid = 1'b1; wr_data = 8'h49;
        wait_cycles(5);
        chk("fill_stall_level", 32'(level[0]), 32'd8);
        stub_hold = 1'b0;
        begin
            int t = 0;
            while (!wr_ready[0] && t < 50) begin
                @(negedge baud_clk);
                t++;
            end
            chk("fill_resume", 32'(t < 50), 32'd1);
        end
        @(negedge baud_clk);
        wr_valid = 1'b0;
        wait_cycles(250);

        // Flush with one frame in flight and 5 queued
        stub_hold = 1'b1;
        for (int b = 0; b < 6; b++) push_hold(8'(8'h60 + b));
        chk("flush_pre_level", 32'(level[0]), 32'd5);
        snap0 = fd_cnt[0];
        flush = 1'b1; wr_valid = 1'b1; wr_data = 8'hEE;
        #1;
        chk("flush_wr_ready", 32'(wr_ready[0]), 32'd0);
        @(negedge baud_clk);
        flush = 1'b0; wr_valid = 1'b0;
        chk("flush_level", 32'(level[0]), 32'd0);
        stub_hold = 1'b0;
        wait_cycles(40);
        chk("flush_fd_count", 32'(fd_cnt[0] - snap0), 32'd1);
        chk("flush_no_launch", 32'(tx_start[0]), 32'd0);
        wait_cycles(10);

        // Reset mid-frame
        wr_valid = 1'b1;
        for (int b = 0; b < 4; b++) begin
            wr_data = 8'(8'h80 + b);
            @(negedge baud_clk);
        end
        wr_valid = 1'b0;
        wait_cycles(4);
        chk("midreset_level_before", 32'(level[0]), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge baud_clk);
        rst_n = 1'b1;
        snap0 = fd_cnt[0];
        wait_cycles(20);
        chk("postreset_idle_start", 32'(tx_start[0]), 32'd0);
        chk("postreset_fd", 32'(fd_cnt[0] - snap0), 32'd0);

        // Randomized traffic
        rand_len = 1'b1;
        repeat (3000) begin
            @(negedge baud_clk);
            wr_valid = ($urandom_range(0, 99) < 55);
            wr_data  = 8'($urandom);
            flush    = ($urandom_range(0, 99) < 2);
        end
        @(negedge baud_clk);
        wr_valid = 1'b0; flush = 1'b0;
        wait_cycles(300);
        chk("drain_empty0", 32'(empty[0]), 32'd1);
        chk("drain_empty1", 32'(empty[1]), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
